reg_writeback_ctrl: RTL and testbench

- Write-side controller for the 8x16 register file. It merges ALU and load results into one registered write port (reg_write_en/dest/data).
- Keeps a per-register busy scoreboard that is set at issue and cleared on write.
- Gives the decode stage per-operand hazard and bypass signals.
- Sits between the execute/memory stages and the register file write port.

---
 rtl/reg_writeback_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_reg_writeback_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl
//   Write-side controller for the 8x16 register file. ALU and load results are
//   merged into one registered write port. A one-entry buffer parks a load that
//   collides with an ALU result. A per-register busy scoreboard is set at issue
//   and cleared on writeback. Decode gets per-operand hazard/bypass status.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   issue_valid/dest/wr          instruction issue (sets busy[dest] when wr)
//   alu_valid/dest/data          ALU result, always accepted
//   ld_valid/ready/dest/data     load result handshake (ready low while buffer held)
//   reg_write_en/dest/data       registered register file write port
//   rd_addr_1/2                  decode operand addresses
//   hazard_1/2                   operand busy and not on the write port: stall
//   byp_hit_1/2, byp_data_1/2    operand busy and on the write port: bypass
//   busy                         scoreboard, bit 0 always 0
//   err                          sticky protocol error

module reg_writeback_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_dest,
  input  logic                     issue_wr,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_dest,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_W-1:0]        ld_dest,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     reg_write_en,
  output logic [ADDR_W-1:0]        reg_write_dest,
  output logic [DATA_W-1:0]        reg_write_data,
  input  logic [ADDR_W-1:0]        rd_addr_1,
  input  logic [ADDR_W-1:0]        rd_addr_2,
  output logic                     hazard_1,
  output logic                     hazard_2,
  output logic                     byp_hit_1,
  output logic                     byp_hit_2,
  output logic [DATA_W-1:0]        byp_data_1,
  output logic [DATA_W-1:0]        byp_data_2,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic                     err
);

  localparam int unsigned NumRegs = 1 << ADDR_W;

  // Load buffer states
  localparam logic [0:0] LD_EMPTY = 1'b0;
  localparam logic [0:0] LD_HELD  = 1'b1;

  // State
  logic [0:0]         ld_state_q, ld_state_d;
  logic [ADDR_W-1:0]  buf_dest_q, buf_dest_d;
  logic [DATA_W-1:0]  buf_data_q, buf_data_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_dest_q, wr_dest_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [NumRegs-1:0] busy_q, busy_d;
  logic               err_q, err_d;

  // Selection helpers
  logic               held;
  logic               ld_accept;
  logic               sel_valid;
  logic [ADDR_W-1:0]  sel_dest;
  logic [DATA_W-1:0]  sel_data;

  // Error sources
  logic               err_alu_idle;
  logic               err_ld_idle;
  logic               err_overtake;

  assign held      = (ld_state_q == LD_HELD);
  assign ld_ready  = (ld_state_q == LD_EMPTY);
  assign ld_accept = ld_valid & ld_ready;

  // Write-stage source select: ALU > held load > incoming load.
  always_comb begin
    ld_state_d = ld_state_q;
    buf_dest_d = buf_dest_q;
    buf_data_d = buf_data_q;
    sel_valid  = 1'b0;
    sel_dest   = wr_dest_q;
    sel_data   = wr_data_q;

    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_dest  = alu_dest;
      sel_data  = alu_data;
      // A colliding load is parked; ld_accept is only possible while EMPTY.
      if (ld_accept) begin
        ld_state_d = LD_HELD;
        buf_dest_d = ld_dest;
        buf_data_d = ld_data;
      end
    end else if (held) begin
      sel_valid  = 1'b1;
      sel_dest   = buf_dest_q;
      sel_data   = buf_data_q;
      ld_state_d = LD_EMPTY;
    end else if (ld_accept) begin
      sel_valid = 1'b1;
      sel_dest  = ld_dest;
      sel_data  = ld_data;
    end
  end

  // r0 results are consumed but never reach the register file.
  always_comb begin
    wr_en_d   = sel_valid & (sel_dest != '0);
    wr_dest_d = wr_dest_q;
    wr_data_d = wr_data_q;
    if (sel_valid) begin
      wr_dest_d = sel_dest;
      wr_data_d = sel_data;
    end
  end

  // Scoreboard: clear on the write currently on the port, then apply the
  // issue so a same-edge set from a newer producer wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) begin
      busy_d[wr_dest_q] = 1'b0;
    end
    if (issue_valid && issue_wr) begin
      busy_d[issue_dest] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Protocol errors: a result nobody was waiting for, or an ALU result that
  // would retire ahead of an older parked load to the same register.
  always_comb begin
    err_alu_idle = alu_valid & (alu_dest != '0) & ~busy_q[alu_dest];
    err_ld_idle  = ld_accept & (ld_dest != '0) & ~busy_q[ld_dest];
    err_overtake = alu_valid & held & (alu_dest == buf_dest_q);
    err_d        = err_q | err_alu_idle | err_ld_idle | err_overtake;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state_q <= LD_EMPTY;
      buf_dest_q <= '0;
      buf_data_q <= '0;
      wr_en_q    <= 1'b0;
      wr_dest_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      ld_state_q <= ld_state_d;
      buf_dest_q <= buf_dest_d;
      buf_data_q <= buf_data_d;
      wr_en_q    <= wr_en_d;
      wr_dest_q  <= wr_dest_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Operand status. A busy operand whose producer is on the write port this
  // cycle can be bypassed; otherwise decode must wait.
  logic wr_match_1, wr_match_2;

  always_comb begin
    wr_match_1 = wr_en_q & (wr_dest_q == rd_addr_1) & (rd_addr_1 != '0);
    wr_match_2 = wr_en_q & (wr_dest_q == rd_addr_2) & (rd_addr_2 != '0);
    byp_hit_1  = busy_q[rd_addr_1] & wr_match_1;
    byp_hit_2  = busy_q[rd_addr_2] & wr_match_2;
    hazard_1   = busy_q[rd_addr_1] & ~wr_match_1 & (rd_addr_1 != '0);
    hazard_2   = busy_q[rd_addr_2] & ~wr_match_2 & (rd_addr_2 != '0);
  end

  assign byp_data_1     = wr_data_q;
  assign byp_data_2     = wr_data_q;
  assign reg_write_en   = wr_en_q;
  assign reg_write_dest = wr_dest_q;
  assign reg_write_data = wr_data_q;
  assign busy           = busy_q;
  assign err            = err_q;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Bench for reg_writeback_ctrl: directed scenarios with literal expectations,
// plus a queue-based reference model compared against the DUT every cycle.

module tb_reg_writeback_ctrl;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [2:0]  issue_dest;
  logic        issue_wr;
  logic        alu_valid;
  logic [2:0]  alu_dest;
  logic [15:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_dest;
  logic [15:0] ld_data;
  logic        reg_write_en;
  logic [2:0]  reg_write_dest;
  logic [15:0] reg_write_data;
  logic [2:0]  rd_addr_1;
  logic [2:0]  rd_addr_2;
  logic        hazard_1;
  logic        hazard_2;
  logic        byp_hit_1;
  logic        byp_hit_2;
  logic [15:0] byp_data_1;
  logic [15:0] byp_data_2;
  logic [7:0]  busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  reg_writeback_ctrl #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_dest     (issue_dest),
    .issue_wr       (issue_wr),
    .alu_valid      (alu_valid),
    .alu_dest       (alu_dest),
    .alu_data       (alu_data),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_dest        (ld_dest),
    .ld_data        (ld_data),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data),
    .rd_addr_1      (rd_addr_1),
    .rd_addr_2      (rd_addr_2),
    .hazard_1       (hazard_1),
    .hazard_2       (hazard_2),
    .byp_hit_1      (byp_hit_1),
    .byp_hit_2      (byp_hit_2),
    .byp_data_1     (byp_data_1),
    .byp_data_2     (byp_data_2),
    .busy           (busy),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]  dest;
    logic [15:0] data;
  } res_t;

  res_t        m_parked[$];   // loads waiting behind ALU results
  logic [7:0]  m_busy;
  logic        m_err;
  logic        m_we;
  logic [2:0]  m_wdest;
  logic [15:0] m_wdata;
  bit          model_live = 0;
  bit          m_take_ld;
  bit          m_nw_v;
  res_t        m_nw;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_parked.delete();
        m_busy     = '0;
        m_err      = 1'b0;
        m_we       = 1'b0;
        m_wdest    = '0;
        m_wdata    = '0;
        model_live = 1;
      end else if (model_live) begin
        m_take_ld = ld_valid && (m_parked.size() == 0);
        // errors judged on the scoreboard as it stood before this edge
        if (alu_valid && alu_dest != 0 && !m_busy[alu_dest]) m_err = 1'b1;
        if (m_take_ld && ld_dest != 0 && !m_busy[ld_dest]) m_err = 1'b1;
        if (alu_valid && m_parked.size() > 0 && m_parked[0].dest == alu_dest) m_err = 1'b1;
        if (m_we) m_busy[m_wdest] = 1'b0;
        if (issue_valid && issue_wr && issue_dest != 0) m_busy[issue_dest] = 1'b1;
        m_nw_v = 0;
        if (alu_valid) begin
          m_nw_v = 1;
          m_nw   = '{alu_dest, alu_data};
          if (m_take_ld) m_parked.push_back('{ld_dest, ld_data});
        end else if (m_parked.size() > 0) begin
          m_nw_v = 1;
          m_nw   = m_parked.pop_front();
        end else if (m_take_ld) begin
          m_nw_v = 1;
          m_nw   = '{ld_dest, ld_data};
        end
        m_we = m_nw_v && (m_nw.dest != 0);
        if (m_we) begin
          m_wdest = m_nw.dest;
          m_wdata = m_nw.data;
        end
      end
    end
  end

  // Per-cycle compare on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        chk("m_we", reg_write_en, m_we);
        if (m_we) begin
          chk("m_dest", reg_write_dest, m_wdest);
          chk("m_data", reg_write_data, m_wdata);
          chk("m_byp_data_1", byp_data_1, m_wdata);
          chk("m_byp_data_2", byp_data_2, m_wdata);
        end
        chk("m_busy", busy, m_busy);
        chk("m_err", err, m_err);
        chk("m_ld_ready", ld_ready, m_parked.size() == 0);
        chk("m_hazard_1", hazard_1,
            rd_addr_1 != 0 && m_busy[rd_addr_1] && !(m_we && m_wdest == rd_addr_1));
        chk("m_byp_hit_1", byp_hit_1,
            rd_addr_1 != 0 && m_busy[rd_addr_1] && m_we && m_wdest == rd_addr_1);
        chk("m_hazard_2", hazard_2,
            rd_addr_2 != 0 && m_busy[rd_addr_2] && !(m_we && m_wdest == rd_addr_2));
        chk("m_byp_hit_2", byp_hit_2,
            rd_addr_2 != 0 && m_busy[rd_addr_2] && m_we && m_wdest == rd_addr_2);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    rd_addr_2 = rd_addr_2 + 3'd1;  // sweep the second operand over all registers
  endtask

  task automatic clear_in();
    issue_valid = 1'b0;
    issue_dest  = '0;
    issue_wr    = 1'b0;
    alu_valid   = 1'b0;
    alu_dest    = '0;
    alu_data    = '0;
    ld_valid    = 1'b0;
    ld_dest     = '0;
    ld_data     = '0;
  endtask

  task automatic do_issue(input logic [2:0] d);
    clear_in();
    issue_valid = 1'b1;
    issue_wr    = 1'b1;
    issue_dest  = d;
    tick();
    clear_in();
  endtask

  initial begin
    rst       = 1'b1;
    rd_addr_1 = '0;
    rd_addr_2 = '0;
    clear_in();

    // Reset with a load pending
    ld_valid = 1'b1;
    ld_dest  = 3'd5;
    ld_data  = 16'h7777;
    tick();
    tick();
    rst = 1'b0;
    clear_in();
    #1;
    chk("rst_we", reg_write_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_err", err, 0);

    // Simple ALU writeback with bypass
    do_issue(3'd3);
    alu_valid = 1'b1;
    alu_dest  = 3'd3;
    alu_data  = 16'h1234;
    #1;
    chk("alu_busy3_set", busy[3], 1);
    tick();
    clear_in();
    rd_addr_1 = 3'd3;
    #1;
    chk("alu_we", reg_write_en, 1);
    chk("alu_dest", reg_write_dest, 3);
    chk("alu_data", reg_write_data, 16'h1234);
    chk("alu_byp_hit_1", byp_hit_1, 1);
    chk("alu_byp_data_1", byp_data_1, 16'h1234);
    chk("alu_hazard_1", hazard_1, 0);
    tick();
    #1;
    chk("alu_busy3_clr", busy[3], 0);
    chk("alu_we_idle", reg_write_en, 0);

    // ALU/load collision
    do_issue(3'd2);
    do_issue(3'd5);
    alu_valid = 1'b1;
    alu_dest  = 3'd2;
    alu_data  = 16'hAAAA;
    ld_valid  = 1'b1;
    ld_dest   = 3'd5;
    ld_data   = 16'h5555;
    tick();
    clear_in();
    rd_addr_1 = 3'd5;
    #1;
    chk("col1_we", reg_write_en, 1);
    chk("col1_dest", reg_write_dest, 2);
    chk("col1_data", reg_write_data, 16'hAAAA);
    chk("col1_ld_ready", ld_ready, 0);
    chk("col1_hazard_1", hazard_1, 1);
    tick();
    #1;
    chk("col2_we", reg_write_en, 1);
    chk("col2_dest", reg_write_dest, 5);
    chk("col2_data", reg_write_data, 16'h5555);
    chk("col2_byp_hit_1", byp_hit_1, 1);
    tick();
    #1;
    chk("col3_ld_ready", ld_ready, 1);
    chk("col3_busy", busy, 0);

    // Load to r4 starved by three back-to-back ALU results
    do_issue(3'd4);
    do_issue(3'd6);
    do_issue(3'd7);
    do_issue(3'd1);
    alu_valid = 1'b1;
    alu_dest  = 3'd6;
    alu_data  = 16'h0606;
    ld_valid  = 1'b1;
    ld_dest   = 3'd4;
    ld_data   = 16'h4444;
    tick();
    clear_in();
    rd_addr_1 = 3'd4;
    alu_valid = 1'b1;
    alu_dest  = 3'd7;
    alu_data  = 16'h0707;
    #1;
    chk("stv_b_ld_ready", ld_ready, 0);
    chk("stv_b_hazard_1", hazard_1, 1);
    tick();
    clear_in();
    alu_valid = 1'b1;
    alu_dest  = 3'd1;
    alu_data  = 16'h0101;
    #1;
    chk("stv_c_ld_ready", ld_ready, 0);
    chk("stv_c_hazard_1", hazard_1, 1);
    tick();
    clear_in();
    #1;
    chk("stv_d_ld_ready", ld_ready, 0);
    chk("stv_d_hazard_1", hazard_1, 1);
    chk("stv_d_dest", reg_write_dest, 1);
    tick();
    #1;
    chk("stv_e_we", reg_write_en, 1);
    chk("stv_e_dest", reg_write_dest, 4);
    chk("stv_e_data", reg_write_data, 16'h4444);
    chk("stv_e_byp_hit_1", byp_hit_1, 1);
    chk("stv_e_hazard_1", hazard_1, 0);
    chk("stv_e_err", err, 0);

    // r0 result dropped, then an unexpected result sets err
    alu_valid = 1'b1;
    alu_dest  = 3'd0;
    alu_data  = 16'hFFFF;
    tick();
    clear_in();
    #1;
    chk("r0_we", reg_write_en, 0);
    chk("r0_busy", busy, 0);
    chk("r0_err", err, 0);
    alu_valid = 1'b1;
    alu_dest  = 3'd6;
    alu_data  = 16'h6666;
    tick();
    clear_in();
    #1;
    chk("e6_we", reg_write_en, 1);
    chk("e6_dest", reg_write_dest, 6);
    chk("e6_data", reg_write_data, 16'h6666);
    chk("e6_err", err, 1);
    tick();
    tick();
    #1;
    chk("e6_err_sticky", err, 1);

    // Issue of r1 racing its own writeback
    rst = 1'b1;
    clear_in();
    tick();
    rst = 1'b0;
    do_issue(3'd1);
    alu_valid = 1'b1;
    alu_dest  = 3'd1;
    alu_data  = 16'h0101;
    tick();
    clear_in();
    issue_valid = 1'b1;
    issue_wr    = 1'b1;
    issue_dest  = 3'd1;
    #1;
    chk("race_we", reg_write_en, 1);
    chk("race_dest", reg_write_dest, 1);
    tick();
    clear_in();
    rd_addr_1 = 3'd1;
    #1;
    chk("race_busy1", busy[1], 1);
    chk("race_hazard_1", hazard_1, 1);
    chk("race_byp_hit_1", byp_hit_1, 0);
    tick();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
